// File: rtl/wb_arbiter_if.sv
// Writeback bus bundle: ALU/load/FPU result sources in, register-file write port out.
// master = result producers and register-file side, slave = the wb_arbiter.
interface wb_arbiter_if #(
   parameter int DATA_W = 32
);
   logic              alu_valid;
   logic              alu_fmode;
   logic [4:0]        alu_reg;
   logic [DATA_W-1:0] alu_data;

   logic              mem_valid;
   logic              mem_ready;
   logic              mem_fmode;
   logic [4:0]        mem_reg;
   logic [DATA_W-1:0] mem_data;

   logic              fpu_valid;
   logic              fpu_ready;
   logic              fpu_fmode;
   logic [4:0]        fpu_reg;
   logic [DATA_W-1:0] fpu_data;

   logic              wenable;
   logic              wfmode;
   logic [4:0]        wreg;
   logic [DATA_W-1:0] wdata;

   modport master (
      output alu_valid, alu_fmode, alu_reg, alu_data,
      output mem_valid, mem_fmode, mem_reg, mem_data,
      input  mem_ready,
      output fpu_valid, fpu_fmode, fpu_reg, fpu_data,
      input  fpu_ready,
      input  wenable, wfmode, wreg, wdata
   );

   modport slave (
      input  alu_valid, alu_fmode, alu_reg, alu_data,
      input  mem_valid, mem_fmode, mem_reg, mem_data,
      output mem_ready,
      input  fpu_valid, fpu_fmode, fpu_reg, fpu_data,
      output fpu_ready,
      output wenable, wfmode, wreg, wdata
   );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: ALU results bypass, load/FPU results queue in per-source FIFOs.
// Define WB_RR_EN for round-robin MEM/FPU arbitration; default is fixed priority MEM > FPU.
module wb_arbiter #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 32
) (
   input  logic        clk,
   input  logic        rst,
   wb_arbiter_if.slave bus
);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int NSRC  = 2;

   typedef struct packed {
      logic              fmode;
      logic [4:0]        rg;
      logic [DATA_W-1:0] data;
   } entry_t;

   // Source index 0 = MEM (load unit), 1 = FPU.
   logic [NSRC-1:0]  in_valid;
   entry_t           in_ent   [NSRC];
   logic [NSRC-1:0]  ready;
   logic [NSRC-1:0]  push;
   logic [NSRC-1:0]  pop;
   logic [NSRC-1:0]  nonempty;
   logic             any_ne;
   logic             win;

   logic [CNT_W-1:0] cnt_q [NSRC];
   logic [CNT_W-1:0] cnt_d [NSRC];
   logic [PTR_W-1:0] wp_q  [NSRC];
   logic [PTR_W-1:0] wp_d  [NSRC];
   logic [PTR_W-1:0] rp_q  [NSRC];
   logic [PTR_W-1:0] rp_d  [NSRC];
   entry_t           buf_q [NSRC][DEPTH];
   entry_t           buf_d [NSRC][DEPTH];

   logic             wen_q, wen_d;
   entry_t           wout_q, wout_d;

`ifdef WB_RR_EN
   logic             rr_q, rr_d;
`endif

   always_comb begin
      in_valid  = {bus.fpu_valid, bus.mem_valid};
      in_ent[0] = {bus.mem_fmode, bus.mem_reg, bus.mem_data};
      in_ent[1] = {bus.fpu_fmode, bus.fpu_reg, bus.fpu_data};
   end

   // Arbitration looks only at registered counts, so an entry pushed this cycle cannot pop yet.
   always_comb begin
      for (int s = 0; s < NSRC; s++) begin
         nonempty[s] = (cnt_q[s] != '0);
         ready[s]    = !rst && (cnt_q[s] < CNT_W'(DEPTH));
      end
      push   = in_valid & ready;
      any_ne = |nonempty;
`ifdef WB_RR_EN
      win    = (&nonempty) ? rr_q : nonempty[1];
`else
      win    = !nonempty[0];
`endif
      pop    = '0;
      if (!bus.alu_valid && any_ne) pop[win] = 1'b1;
   end

   always_comb begin
      buf_d = buf_q;
      for (int s = 0; s < NSRC; s++) begin
         cnt_d[s] = cnt_q[s] + CNT_W'(push[s]) - CNT_W'(pop[s]);
         wp_d[s]  = push[s] ? wp_q[s] + PTR_W'(1) : wp_q[s];
         rp_d[s]  = pop[s]  ? rp_q[s] + PTR_W'(1) : rp_q[s];
         if (push[s]) buf_d[s][wp_q[s]] = in_ent[s];
      end
   end

   // Idle cycles hold the last address/data; only the enable drops.
   always_comb begin
      wen_d  = 1'b0;
      wout_d = wout_q;
      if (bus.alu_valid) begin
         wen_d  = 1'b1;
         wout_d = {bus.alu_fmode, bus.alu_reg, bus.alu_data};
      end else if (any_ne) begin
         wen_d  = 1'b1;
         wout_d = buf_q[win][rp_q[win]];
      end
   end

`ifdef WB_RR_EN
   always_comb begin
      rr_d = rr_q;
      if (!bus.alu_valid && any_ne) rr_d = ~win;
   end
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int s = 0; s < NSRC; s++) begin
            cnt_q[s] <= '0;
            wp_q[s]  <= '0;
            rp_q[s]  <= '0;
         end
         wen_q  <= 1'b0;
         wout_q <= '0;
`ifdef WB_RR_EN
         rr_q   <= 1'b0;
`endif
      end else begin
         for (int s = 0; s < NSRC; s++) begin
            cnt_q[s] <= cnt_d[s];
            wp_q[s]  <= wp_d[s];
            rp_q[s]  <= rp_d[s];
         end
         wen_q  <= wen_d;
         wout_q <= wout_d;
`ifdef WB_RR_EN
         rr_q   <= rr_d;
`endif
      end
   end

   // Storage needs no reset: occupancy is tracked by the counters alone.
   always_ff @(posedge clk) begin
      buf_q <= buf_d;
   end

   assign bus.mem_ready = ready[0];
   assign bus.fpu_ready = ready[1];
   assign bus.wenable   = wen_q;
   assign bus.wfmode    = wout_q.fmode;
   assign bus.wreg      = wout_q.rg;
   assign bus.wdata     = wout_q.data;
endmodule

// File: tb/tb_wb_arbiter.sv
// Scoreboard bench for wb_arbiter: stimulus queues expected writes, a negedge monitor checks them.
module tb_wb_arbiter;
   logic clk = 1'b0;
   logic rst = 1'b1;

   wb_arbiter_if #(.DATA_W(32)) bus ();

   wb_arbiter #(.DEPTH(4), .DATA_W(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        f;
      logic [4:0]  r;
      logic [31:0] d;
   } wr_t;

   wr_t exp_q[$];
   wr_t mon_e;
   int  tests = 0;
   int  fails = 0;

   always @(negedge clk) begin
      if (bus.wenable === 1'b1) begin
         tests++;
         if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_unexpected: got f=%0b r=%0d d=%h, required no write",
                     bus.wfmode, bus.wreg, bus.wdata);
         end else begin
            mon_e = exp_q.pop_front();
            if ({bus.wfmode, bus.wreg, bus.wdata} !== mon_e) begin
               fails++;
               $display("FAIL sb_write: got f=%0b r=%0d d=%h, required f=%0b r=%0d d=%h",
                        bus.wfmode, bus.wreg, bus.wdata, mon_e.f, mon_e.r, mon_e.d);
            end
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: got %h, required %h", name, act, req);
      end
   endtask

   task automatic idle_all;
      bus.alu_valid = 1'b0; bus.alu_fmode = 1'b0; bus.alu_reg = '0; bus.alu_data = '0;
      bus.mem_valid = 1'b0; bus.mem_fmode = 1'b0; bus.mem_reg = '0; bus.mem_data = '0;
      bus.fpu_valid = 1'b0; bus.fpu_fmode = 1'b0; bus.fpu_reg = '0; bus.fpu_data = '0;
   endtask

   task automatic alu_put(input logic f, input logic [4:0] r, input logic [31:0] d);
      bus.alu_valid = 1'b1; bus.alu_fmode = f; bus.alu_reg = r; bus.alu_data = d;
      exp_q.push_back({f, r, d});
   endtask

   task automatic do_reset;
      idle_all();
      rst = 1'b1;
      tick();
      rst = 1'b0;
   endtask

   initial begin
      // Reset held two cycles with every valid asserted
      idle_all();
      rst = 1'b1;
      bus.alu_valid = 1'b1; bus.mem_valid = 1'b1; bus.fpu_valid = 1'b1;
      bus.mem_data = 32'h1111_1111; bus.fpu_data = 32'h2222_2222; bus.alu_data = 32'h3333_3333;
      for (int i = 0; i < 2; i++) begin
         tick();
         chk("rst_wenable", 32'(bus.wenable), 32'd0);
         chk("rst_mem_ready", 32'(bus.mem_ready), 32'd0);
         chk("rst_fpu_ready", 32'(bus.fpu_ready), 32'd0);
      end
      chk("rst_wreg", 32'(bus.wreg), 32'd0);
      chk("rst_wdata", bus.wdata, 32'd0);
      chk("rst_wfmode", 32'(bus.wfmode), 32'd0);
      idle_all();
      rst = 1'b0;
      tick();
      chk("post_rst_wenable", 32'(bus.wenable), 32'd0);
      chk("post_rst_mem_ready", 32'(bus.mem_ready), 32'd1);
      chk("post_rst_fpu_ready", 32'(bus.fpu_ready), 32'd1);
      tick(); tick();

      // ALU single write, one-cycle latency
      alu_put(1'b0, 5'd5, 32'hDEAD_BEEF);
      tick();
      idle_all();
      chk("alu_wenable_n1", 32'(bus.wenable), 32'd1);
      chk("alu_wreg", 32'(bus.wreg), 32'd5);
      chk("alu_wdata", bus.wdata, 32'hDEAD_BEEF);
      tick();
      chk("alu_wenable_n2", 32'(bus.wenable), 32'd0);
      chk("hold_wdata", bus.wdata, 32'hDEAD_BEEF);

      // FIFO path latency: push in cycle n, write visible in n+2
      bus.mem_valid = 1'b1; bus.mem_fmode = 1'b0; bus.mem_reg = 5'd9; bus.mem_data = 32'h0000_0055;
      exp_q.push_back({1'b0, 5'd9, 32'h0000_0055});
      tick();
      idle_all();
      chk("mem_lat_n1", 32'(bus.wenable), 32'd0);
      tick();
      chk("mem_lat_n2", 32'(bus.wenable), 32'd1);
      tick();
      chk("mem_lat_n3", 32'(bus.wenable), 32'd0);

      // Backpressure under continuous ALU traffic
      for (int i = 0; i < 5; i++) begin
         alu_put(1'b1, 5'(20 + i), 32'hA000_0000 + 32'(i));
         bus.mem_valid = 1'b1; bus.mem_fmode = 1'b0;
         bus.mem_reg = 5'(i + 1); bus.mem_data = 32'h0000_0100 + 32'(i);
         chk("bp_mem_ready", 32'(bus.mem_ready), (i < 4) ? 32'd1 : 32'd0);
         tick();
      end
      idle_all();
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b0, 5'(i + 1), 32'h0000_0100 + 32'(i)});
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("bp_drain_wenable", 32'(bus.wenable), 32'd1);
      end
      tick();
      chk("bp_drain_done", 32'(bus.wenable), 32'd0);

      // Contention MEM {r1,r2} vs FPU {f3,f4}
      do_reset();
`ifdef WB_RR_EN
      exp_q.push_back({1'b0, 5'd1, 32'h0000_00A1});
      exp_q.push_back({1'b1, 5'd3, 32'h0000_00F3});
      exp_q.push_back({1'b0, 5'd2, 32'h0000_00A2});
      exp_q.push_back({1'b1, 5'd4, 32'h0000_00F4});
`else
      exp_q.push_back({1'b0, 5'd1, 32'h0000_00A1});
      exp_q.push_back({1'b0, 5'd2, 32'h0000_00A2});
      exp_q.push_back({1'b1, 5'd3, 32'h0000_00F3});
      exp_q.push_back({1'b1, 5'd4, 32'h0000_00F4});
`endif
      bus.mem_valid = 1'b1; bus.mem_fmode = 1'b0; bus.mem_reg = 5'd1; bus.mem_data = 32'h0000_00A1;
      bus.fpu_valid = 1'b1; bus.fpu_fmode = 1'b1; bus.fpu_reg = 5'd3; bus.fpu_data = 32'h0000_00F3;
      tick();
      bus.mem_reg = 5'd2; bus.mem_data = 32'h0000_00A2;
      bus.fpu_reg = 5'd4; bus.fpu_data = 32'h0000_00F4;
      tick();
      idle_all();
      for (int i = 0; i < 6; i++) tick();
      chk("cont_drained", 32'(exp_q.size()), 32'd0);

      // Full FIFO: refused push in the same cycle as a pop
      do_reset();
      for (int i = 0; i < 4; i++) begin
         alu_put(1'b0, 5'd15, 32'hB000_0000 + 32'(i));
         bus.mem_valid = 1'b1; bus.mem_fmode = 1'b1;
         bus.mem_reg = 5'(10 + i); bus.mem_data = 32'h0000_00C0 + 32'(i);
         tick();
      end
      idle_all();
      bus.mem_valid = 1'b1; bus.mem_reg = 5'd31; bus.mem_data = 32'h0000_0BAD;
      chk("full_ready_low", 32'(bus.mem_ready), 32'd0);
      for (int i = 0; i < 4; i++) exp_q.push_back({1'b1, 5'(10 + i), 32'h0000_00C0 + 32'(i)});
      tick();
      chk("full_ready_back", 32'(bus.mem_ready), 32'd1);
      idle_all();
      for (int i = 0; i < 5; i++) tick();
      chk("full_wenable_idle", 32'(bus.wenable), 32'd0);

      // Reset mid-operation discards buffered FPU entries
      for (int i = 0; i < 2; i++) begin
         alu_put(1'b1, 5'd7, 32'hC000_0000 + 32'(i));
         bus.fpu_valid = 1'b1; bus.fpu_fmode = 1'b1;
         bus.fpu_reg = 5'(i + 1); bus.fpu_data = 32'h0000_0E00 + 32'(i);
         tick();
      end
      do_reset();
      chk("mid_rst_wenable", 32'(bus.wenable), 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("mid_rst_idle", 32'(bus.wenable), 32'd0);
      chk("mid_rst_fpu_ready", 32'(bus.fpu_ready), 32'd1);

      tick();
      chk("sb_empty", 32'(exp_q.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
